// File: rtl/bcd_display_scan.sv
// Four-digit common-anode scanner for a captured 3-digit BCD count plus overflow flag.
// Optional overflow blinking is built when the macro OVF_BLINK_EN is defined.
module bcd_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 4,
  parameter int BLINK_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       ovf_in,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low; non-decimal codes go blank.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (code)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  logic [3:0]       r_s2;
  logic [3:0]       r_s1;
  logic [3:0]       r_s0;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             w_tick;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;
  logic             w_dark;

  // Snapshot of the counter value; only a load strobe changes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2  <= 4'd0;
      r_s1  <= 4'd0;
      r_s0  <= 4'd0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_s2  <= d2;
      r_s1  <= d1;
      r_s0  <= d0;
      r_ovf <= ovf_in;
    end
  end

  assign w_tick = (r_cnt == CNT_MAX);

  // Scan prescaler and digit index; a load never disturbs these.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef OVF_BLINK_EN
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_phase;

  // Blink timebase runs only while overflow is shown, so a cleared flag is steady.
  always_ff @(posedge clk) begin
    if (reset || !r_ovf) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_tick) begin
      if (r_blk_cnt == BLK_MAX) begin
        r_blk_cnt <= '0;
        r_phase   <= ~r_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
    end
  end

  assign w_dark = r_ovf & r_phase;
`else
  assign w_dark = 1'b0;
`endif

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    case (r_idx)
      2'd0:    w_seg_nxt = f_decode(r_s0);
      2'd1:    w_seg_nxt = f_decode(r_s1);
      2'd2:    w_seg_nxt = f_decode(r_s2);
      default: w_seg_nxt = r_ovf ? SEG_E : SEG_BLANK;
    endcase
  end

  assign w_an_nxt = ~(4'b0001 << r_idx);
  assign w_dp_nxt = ({1'b0, r_idx} == 3'(DP_POS)) ? 1'b0 : 1'b1;

  // Registered pin drive: one cycle behind the index and snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= w_dark ? AN_OFF : w_an_nxt;
      seg <= w_seg_nxt;
      dp  <= w_dp_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a short scan period and decimal point on digit 2.
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       ovf_in;
  logic [3:0] d2, d1, d0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

`ifdef OVF_BLINK_EN
  localparam logic [3:0] AN2_OVF = 4'b1111;
  localparam logic [3:0] AN3_OVF = 4'b1111;
`else
  localparam logic [3:0] AN2_OVF = 4'b1011;
  localparam logic [3:0] AN3_OVF = 4'b0111;
`endif

  bcd_display_scan #(
    .REFRESH_DIV(4),
    .DP_POS     (2),
    .BLINK_TICKS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .ovf_in(ovf_in),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp);
    chk({tag, ".an"},  {3'b000, an},     {3'b000, e_an});
    chk({tag, ".seg"}, seg,              e_seg);
    chk({tag, ".dp"},  {6'b000000, dp},  {6'b000000, e_dp});
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] u, input logic o);
    d2 = h; d1 = t; d0 = u; ovf_in = o;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; ovf_in = 1'b0;
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;

    tick(3);
    expect_out("reset", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;

    tick(1); expect_out("rel_d0",  4'b1110, 7'b1000000, 1'b1);
    tick(4); expect_out("rel_d1",  4'b1101, 7'b1000000, 1'b1);
    tick(4); expect_out("rel_d2",  4'b1011, 7'b1000000, 1'b0);
    tick(4); expect_out("rel_d3",  4'b0111, 7'b1111111, 1'b1);
    tick(4); expect_out("rel_wrap", 4'b1110, 7'b1000000, 1'b1);

    do_load(4'd1, 4'd2, 4'd3, 1'b0);
    tick(1); expect_out("n123_d0", 4'b1110, 7'b0110000, 1'b1);
    tick(2); expect_out("n123_d1", 4'b1101, 7'b0100100, 1'b1);
    tick(4); expect_out("n123_d2", 4'b1011, 7'b1111001, 1'b0);
    tick(4); expect_out("n123_d3", 4'b0111, 7'b1111111, 1'b1);
    tick(4); expect_out("n123_wrap", 4'b1110, 7'b0110000, 1'b1);

    do_load(4'd9, 4'd9, 4'd9, 1'b1);
    tick(1); expect_out("n999_d0", 4'b1110, 7'b0010000, 1'b1);
    tick(2); expect_out("n999_d1", 4'b1101, 7'b0010000, 1'b1);
    tick(4); expect_out("n999_d2", AN2_OVF, 7'b0010000, 1'b0);
    tick(4); expect_out("n999_d3", AN3_OVF, 7'b0000110, 1'b1);
    tick(4); expect_out("n999_wrap", 4'b1110, 7'b0010000, 1'b1);

    do_load(4'd0, 4'd4, 4'd5, 1'b0);
    tick(1); expect_out("n045_d0", 4'b1110, 7'b0010010, 1'b1);
    tick(2); expect_out("n045_d1", 4'b1101, 7'b0011001, 1'b1);
    tick(4); expect_out("n045_d2", 4'b1011, 7'b1000000, 1'b0);
    tick(4); expect_out("n045_d3", 4'b0111, 7'b1111111, 1'b1);
    tick(4); expect_out("n045_wrap", 4'b1110, 7'b0010010, 1'b1);

    do_load(4'd0, 4'd4, 4'hC, 1'b0);
    tick(1); expect_out("codeC_d0", 4'b1110, 7'b1111111, 1'b1);
    tick(2); expect_out("codeC_d1", 4'b1101, 7'b0011001, 1'b1);
    tick(2); expect_out("codeC_hold", 4'b1101, 7'b0011001, 1'b1);

    do_load(4'd7, 4'd8, 4'd6, 1'b0);
    tick(1); expect_out("load_tick", 4'b1011, 7'b1111000, 1'b0);

    reset = 1'b1;
    d2 = 4'd9; d1 = 4'd9; d0 = 4'd9; ovf_in = 1'b1; load = 1'b1;
    tick(1); expect_out("midrst", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0; load = 1'b0;
    tick(1); expect_out("rst2_d0", 4'b1110, 7'b1000000, 1'b1);
    tick(4); expect_out("rst2_d1", 4'b1101, 7'b1000000, 1'b1);
    tick(8); expect_out("rst2_d3", 4'b0111, 7'b1111111, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
